vmm_arbiter: RTL

- Shares the single-port video memory (8 KB, 13-bit address, 1-cycle synchronous read) between the video fetch engine and a CPU-side requester.
- Sits between the video generator, the CPU bus adapter and the video memory instance, all in the pixel clock domain.
- Video fetches always win. CPU accesses are queued, stalled with a wait signal and completed with an acknowledge.
- Counts contention cycles for debug.

---
 rtl/vmm_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/vmm_arbiter.sv
// vmm_arbiter: shares the single-port video memory between the video fetch
// engine and a CPU-side requester. Video fetches win; the CPU waits on cwait
// and finishes on cack. Optional MAXWAIT bounds CPU starvation.
// Optional macro VMM_ARB_WRITEBUF_EN adds a single-entry posted write buffer.
//
// state    | meaning
// IDLE     | no CPU access in flight; CPU may be granted
// CPU_WR   | write accepted last cycle; cack this cycle
// CPU_RD   | read address presented last cycle; mdo captured into cdo
// CPU_DONE | read data on cdo; cack this cycle
module vmm_arbiter #(
  parameter int AW      = 13,
  parameter int DW      = 8,
  parameter int MAXWAIT = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          vreq,
  input  logic [AW-1:0] va,
  output logic [DW-1:0] vd,
  output logic          vvalid,
  input  logic          creq,
  input  logic          cwr,
  input  logic [AW-1:0] ca,
  input  logic [DW-1:0] cdi,
  output logic [DW-1:0] cdo,
  output logic          cack,
  output logic          cwait,
  output logic [AW-1:0] ma,
  output logic [DW-1:0] mdi,
  output logic          mwe,
  input  logic [DW-1:0] mdo,
  output logic [15:0]   contention
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_WR   = 2'd1,
    CPU_RD   = 2'd2,
    CPU_DONE = 2'd3
  } state_t;

  state_t        r_state, w_next;
  logic [AW-1:0] r_ma;
  logic          r_vtag, r_vvalid;
  logic [DW-1:0] r_vd, r_cdo;
  logic [15:0]   r_cont, r_stall;
  logic          w_run, w_idle, w_starve, w_vgnt, w_cgnt, w_cacc;
  logic [DW-1:0] w_rd_data;

  // Grants are blocked while reset is asserted so the memory port stays quiet.
  assign w_run    = reset;
  assign w_idle   = (r_state == IDLE);
  assign w_starve = (MAXWAIT != 0) && creq && w_idle && (r_stall >= 16'(MAXWAIT));
  assign w_vgnt   = w_run && vreq && !w_starve;

`ifdef VMM_ARB_WRITEBUF_EN
  logic          r_wb_valid, r_hit;
  logic [AW-1:0] r_wb_addr;
  logic [DW-1:0] r_wb_data, r_hit_data;
  logic          w_hit, w_wb_acc, w_hit_rd, w_drain;

  assign w_hit    = r_wb_valid && (ca == r_wb_addr);
  assign w_wb_acc = w_run && creq && cwr && w_idle && !r_wb_valid;
  assign w_hit_rd = w_run && creq && !cwr && w_idle && w_hit;
  // A starved write behind a full buffer forces the drain so it can proceed.
  assign w_drain  = w_run && r_wb_valid && (!vreq || (w_starve && cwr));
  assign w_cgnt   = w_run && creq && !cwr && w_idle && !w_hit && !w_vgnt && !w_drain;
  assign w_cacc   = w_cgnt || w_wb_acc || w_hit_rd;
  assign w_rd_data = r_hit ? r_hit_data : mdo;

  // Posted write buffer: load on accept, clear on drain; latch hit data at grant.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_hit      <= 1'b0;
      r_hit_data <= '0;
    end else begin
      if (w_wb_acc) begin
        r_wb_valid <= 1'b1;
        r_wb_addr  <= ca;
        r_wb_data  <= cdi;
      end else if (w_drain) begin
        r_wb_valid <= 1'b0;
      end
      if (w_idle) begin
        r_hit      <= w_hit_rd;
        r_hit_data <= r_wb_data;
      end
    end
  end
`else
  assign w_cgnt    = w_run && creq && w_idle && !w_vgnt;
  assign w_cacc    = w_cgnt;
  assign w_rd_data = mdo;
`endif

  // Memory port is steered by this cycle's grant; the address holds otherwise.
  always_comb begin
    ma  = r_ma;
    mdi = '0;
    mwe = 1'b0;
    if (w_vgnt) begin
      ma = va;
`ifdef VMM_ARB_WRITEBUF_EN
    end else if (w_drain) begin
      ma  = r_wb_addr;
      mdi = r_wb_data;
      mwe = 1'b1;
`endif
    end else if (w_cgnt) begin
      ma  = ca;
      mdi = cdi;
      mwe = cwr;
    end
  end

  // Next-state logic for the CPU access sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_cacc) w_next = cwr ? CPU_WR : CPU_RD;
      CPU_WR:   w_next = IDLE;
      CPU_RD:   w_next = CPU_DONE;
      CPU_DONE: w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Video/CPU data pipelines, held address, contention and stall counters.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ma     <= '0;
      r_vtag   <= 1'b0;
      r_vvalid <= 1'b0;
      r_vd     <= '0;
      r_cdo    <= '0;
      r_cont   <= '0;
      r_stall  <= '0;
    end else begin
      r_ma     <= ma;
      r_vtag   <= w_vgnt;
      r_vvalid <= r_vtag;
      if (r_vtag) r_vd <= mdo;
      if (r_state == CPU_RD) r_cdo <= w_rd_data;
      if (cwait && (r_cont != 16'hFFFF)) r_cont <= r_cont + 16'd1;
      if (w_cacc) r_stall <= '0;
      else if (creq && w_idle && (r_stall != 16'hFFFF)) r_stall <= r_stall + 16'd1;
    end
  end

  assign cack       = (r_state == CPU_WR) || (r_state == CPU_DONE);
  assign cwait      = creq && !cack;
  assign vd         = r_vd;
  assign vvalid     = r_vvalid;
  assign cdo        = r_cdo;
  assign contention = r_cont;

endmodule
